// File: rtl/inst_fetch.sv
// Instruction-fetch responder: fetches the word at pc over a req/ack port and presents it
// to IF/ID, holding the PC via stallreq and buffering one word while IF output is stalled.
module inst_fetch #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              br,
  input  logic [5:0]        stall,
  output logic              stallreq,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [DATA_W-1:0] inst
);

  typedef enum logic [1:0] {StIdle, StBusy, StDrop, StHold} state_e;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                inst_valid_q, inst_valid_d;
  logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
  logic [DATA_W-1:0]   inst_q, inst_d;
  logic                fetched_q, fetched_d;
  logic [ADDR_W-1:0]   fetched_pc_q, fetched_pc_d;
  logic [DATA_W-1:0]   buf_data_q, buf_data_d;
  logic                have_word;
  logic                done;

  // Only stall[1] concerns the IF stage.
  logic unused_stall;
  assign unused_stall = ^{stall[5:2], stall[0]};

  assign have_word = fetched_q && (pc == fetched_pc_q);
  assign done      = ((state_q == StBusy) && mem_ack) || have_word;
  assign stallreq  = !br && !done;

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    inst_valid_d = inst_valid_q;
    inst_pc_d    = inst_pc_q;
    inst_d       = inst_q;
    fetched_d    = fetched_q;
    fetched_pc_d = fetched_pc_q;
    buf_data_d   = buf_data_q;

    // Bubble unless held by stall[1]; a redirect always kills the IF output.
    if (br || !stall[1]) inst_valid_d = 1'b0;
    if (br) fetched_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!br && !have_word) begin
          mem_req_d  = 1'b1;
          mem_addr_d = pc;
          state_d    = StBusy;
        end
      end
      StBusy: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = StIdle;
          if (!br) begin
            fetched_d    = 1'b1;
            fetched_pc_d = mem_addr_q;
            if (!stall[1]) begin
              inst_d       = mem_rdata;
              inst_pc_d    = mem_addr_q;
              inst_valid_d = 1'b1;
            end else begin
              buf_data_d = mem_rdata;
              state_d    = StHold;
            end
          end
        end else if (br) begin
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = StIdle;
        end
      end
      StHold: begin
        if (br) begin
          buf_data_d = '0;
          state_d    = StIdle;
        end else if (!stall[1]) begin
          inst_d       = buf_data_q;
          inst_pc_d    = fetched_pc_q;
          inst_valid_d = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      inst_valid_q <= 1'b0;
      inst_pc_q    <= '0;
      inst_q       <= '0;
      fetched_q    <= 1'b0;
      fetched_pc_q <= '0;
      buf_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_pc_q    <= inst_pc_d;
      inst_q       <= inst_d;
      fetched_q    <= fetched_d;
      fetched_pc_q <= fetched_pc_d;
      buf_data_q   <= buf_data_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign inst_valid = inst_valid_q;
  assign inst_pc    = inst_pc_q;
  assign inst       = inst_q;

endmodule
